// File: rtl/error_analysis_pkg.sv
// Shared types and helpers for the error-analysis path: state encoding,
// saturating add and popcount width.
package error_analysis_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StAccum  = 2'd1,
        StReport = 2'd2
    } state_e;

    // Widest counter the saturating adder supports.
    localparam int unsigned SatW = 32;

    function automatic int unsigned popcnt_width(input int unsigned n);
        return $clog2(n + 1);
    endfunction

    // Returns {overflow, result}; result clips at 2^w-1.
    function automatic logic [SatW:0] sat_add(input logic [SatW-1:0] a,
                                              input logic [SatW-1:0] b,
                                              input int unsigned     w);
        logic [SatW:0] sum;
        logic [SatW:0] lim;
        sum = {1'b0, a} + {1'b0, b};
        lim = ((SatW + 1)'(1) << w) - (SatW + 1)'(1);
        if (sum > lim) begin
            return {1'b1, lim[SatW-1:0]};
        end
        return {1'b0, sum[SatW-1:0]};
    endfunction

endpackage

// File: rtl/bit_popcount.sv
// Combinational population count of an N-bit word.
module bit_popcount
    import error_analysis_pkg::*;
#(
    parameter int unsigned N = 3
) (
    input  logic [1:N]                   data_i,
    output logic [popcnt_width(N)-1:0]   count_o
);

    localparam int unsigned CntW = popcnt_width(N);

    always_comb begin
        count_o = '0;
        for (int i = 1; i <= N; i++) begin
            count_o = count_o + CntW'(data_i[i]);
        end
    end

endmodule

// File: rtl/error_tally.sv
// Accumulates bit/word flip statistics over WINDOW accepted sent/received
// pairs and presents one report under a valid/ready handshake.
module error_tally
    import error_analysis_pkg::*;
#(
    parameter int unsigned N      = 3,
    parameter int unsigned WINDOW = 16,
    parameter int unsigned CNT_W  = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic                         in_valid,
    input  logic [1:N]                   sent,
    input  logic [1:N]                   received,
    output logic                         in_ready,
    output logic                         busy,
    output logic                         rpt_valid,
    input  logic                         rpt_ready,
    output logic [CNT_W-1:0]             bit_errs,
    output logic [CNT_W-1:0]             word_errs,
    output logic [popcnt_width(N)-1:0]   max_word_errs,
    output logic                         saturated
);

    localparam int unsigned EW   = popcnt_width(N);
    localparam int unsigned IdxW = $clog2(WINDOW + 1);

    state_e           state_q, state_d;
    logic [IdxW-1:0]  idx_q, idx_d;
    logic [CNT_W-1:0] bit_errs_q, bit_errs_d;
    logic [CNT_W-1:0] word_errs_q, word_errs_d;
    logic [EW-1:0]    max_q, max_d;
    logic             sat_q, sat_d;

    logic [EW-1:0]    e;
    logic [SatW:0]    bit_sum;
    logic [SatW:0]    word_sum;

    bit_popcount #(
        .N (N)
    ) u_popcount (
        .data_i  (sent ^ received),
        .count_o (e)
    );

    always_comb begin
        bit_sum  = sat_add(SatW'(bit_errs_q), SatW'(e), CNT_W);
        word_sum = sat_add(SatW'(word_errs_q), SatW'(e != '0), CNT_W);
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        bit_errs_d  = bit_errs_q;
        word_errs_d = word_errs_q;
        max_d       = max_q;
        sat_d       = sat_q;

        case (state_q)
            StIdle: begin
                if (start) begin
                    state_d     = StAccum;
                    idx_d       = '0;
                    bit_errs_d  = '0;
                    word_errs_d = '0;
                    max_d       = '0;
                    sat_d       = 1'b0;
                end
            end
            StAccum: begin
                if (in_valid) begin
                    bit_errs_d  = CNT_W'(bit_sum);
                    word_errs_d = CNT_W'(word_sum);
                    sat_d       = sat_q | bit_sum[SatW] | word_sum[SatW];
                    if (e > max_q) begin
                        max_d = e;
                    end
                    idx_d = idx_q + IdxW'(1);
                    if (idx_q == IdxW'(WINDOW - 1)) begin
                        state_d = StReport;
                    end
                end
            end
            StReport: begin
                if (rpt_ready) begin
                    if (start) begin
                        state_d     = StAccum;
                        idx_d       = '0;
                        bit_errs_d  = '0;
                        word_errs_d = '0;
                        max_d       = '0;
                        sat_d       = 1'b0;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= StIdle;
            idx_q       <= '0;
            bit_errs_q  <= '0;
            word_errs_q <= '0;
            max_q       <= '0;
            sat_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            bit_errs_q  <= bit_errs_d;
            word_errs_q <= word_errs_d;
            max_q       <= max_d;
            sat_q       <= sat_d;
        end
    end

    assign in_ready      = (state_q == StAccum);
    assign busy          = (state_q != StIdle);
    assign rpt_valid     = (state_q == StReport);
    assign bit_errs      = bit_errs_q;
    assign word_errs     = word_errs_q;
    assign max_word_errs = max_q;
    assign saturated     = sat_q;

endmodule

// File: tb/tb_error_tally.sv
// Bench for error_tally: table-driven windows, hand-written corner sequences
// and random traffic, all checked against a behavioural model.
module tb_error_tally;

    localparam int unsigned N   = 3;
    localparam int unsigned WIN = 4;
    localparam int unsigned CW  = 16;
    localparam int          LIM = (1 << CW) - 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, start, in_valid, rpt_ready;
    logic [2:0] sent, received;

    logic          in_ready, busy, rpt_valid, saturated;
    logic [CW-1:0] bit_errs, word_errs;
    logic [1:0]    max_word_errs;

    logic       s_in_ready, s_busy, s_rpt_valid, s_saturated;
    logic [2:0] s_bit_errs, s_word_errs;
    logic [1:0] s_max_word_errs;

    error_tally #(.N(N), .WINDOW(WIN), .CNT_W(CW)) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .in_valid      (in_valid),
        .sent          (sent),
        .received      (received),
        .in_ready      (in_ready),
        .busy          (busy),
        .rpt_valid     (rpt_valid),
        .rpt_ready     (rpt_ready),
        .bit_errs      (bit_errs),
        .word_errs     (word_errs),
        .max_word_errs (max_word_errs),
        .saturated     (saturated)
    );

    error_tally #(.N(N), .WINDOW(WIN), .CNT_W(3)) dut_sat (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .in_valid      (in_valid),
        .sent          (sent),
        .received      (received),
        .in_ready      (s_in_ready),
        .busy          (s_busy),
        .rpt_valid     (s_rpt_valid),
        .rpt_ready     (rpt_ready),
        .bit_errs      (s_bit_errs),
        .word_errs     (s_word_errs),
        .max_word_errs (s_max_word_errs),
        .saturated     (s_saturated)
    );

    int errors = 0;
    int checks = 0;

    // Model: 0 idle, 1 accumulating, 2 report pending; raw unclipped totals.
    int m_mode, m_cnt, m_bits, m_words, m_max;

    typedef struct {
        logic [11:0] s;
        logic [11:0] r;
        int          eb;
        int          ew;
        int          em;
    } win_t;
    win_t tbl[4];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int clip(input int v);
        return (v > LIM) ? LIM : v;
    endfunction

    task automatic model_clear();
        m_cnt = 0; m_bits = 0; m_words = 0; m_max = 0;
    endtask

    task automatic model_edge();
        int e;
        e = $countones(sent ^ received);
        if (!reset) begin
            m_mode = 0;
            model_clear();
        end else if (m_mode == 0) begin
            if (start) begin
                model_clear();
                m_mode = 1;
            end
        end else if (m_mode == 1) begin
            if (in_valid) begin
                m_bits  += e;
                m_words += (e != 0) ? 1 : 0;
                if (e > m_max) m_max = e;
                m_cnt++;
                if (m_cnt == WIN) m_mode = 2;
            end
        end else if (rpt_ready) begin
            if (start) begin
                model_clear();
                m_mode = 1;
            end else begin
                m_mode = 0;
            end
        end
    endtask

    task automatic check_all();
        chk("in_ready", in_ready, m_mode == 1);
        chk("busy", busy, m_mode != 0);
        chk("rpt_valid", rpt_valid, m_mode == 2);
        chk("bit_errs", bit_errs, clip(m_bits));
        chk("word_errs", word_errs, clip(m_words));
        chk("max_word_errs", max_word_errs, m_max);
        chk("saturated", saturated, (m_bits > LIM) || (m_words > LIM));
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic run_window(input int i);
        start = 1'b1;
        step();
        start = 1'b0;
        for (int w = 0; w < 4; w++) begin
            in_valid = 1'b1;
            sent     = tbl[i].s[11-3*w -: 3];
            received = tbl[i].r[11-3*w -: 3];
            step();
        end
        in_valid = 1'b0;
        chk("rpt_latency", rpt_valid, 1);
        chk("tbl_bit_errs", bit_errs, tbl[i].eb);
        chk("tbl_word_errs", word_errs, tbl[i].ew);
        chk("tbl_max", max_word_errs, tbl[i].em);
    endtask

    task automatic handshake_idle();
        rpt_ready = 1'b1;
        step();
        rpt_ready = 1'b0;
        chk("idle_busy", busy, 0);
    endtask

    initial begin
        logic [CW-1:0] hold_bits;

        tbl[0] = '{s: 12'b101_011_110_001, r: 12'b101_011_110_001, eb: 0, ew: 0, em: 0};
        tbl[1] = '{s: 12'b101_111_000_011, r: 12'b010_110_000_001, eb: 5, ew: 3, em: 3};
        tbl[2] = '{s: 12'b001_010_100_000, r: 12'b000_010_101_001, eb: 3, ew: 3, em: 1};
        tbl[3] = '{s: 12'b000_000_000_000, r: 12'b111_111_111_111, eb: 12, ew: 4, em: 3};

        reset = 1'b0; start = 1'b0; in_valid = 1'b0; rpt_ready = 1'b0;
        sent = '0; received = '0;
        m_mode = 0;
        model_clear();
        step();
        step();
        chk("reset_busy", busy, 0);
        chk("reset_bits", bit_errs, 0);
        reset = 1'b1;
        step();

        // Clean channel, mixed errors and a low-weight window.
        for (int i = 0; i < 3; i++) begin
            run_window(i);
            chk("tbl_saturated", saturated, 0);
            handshake_idle();
        end

        // Saturation on the narrow-counter instance.
        run_window(3);
        chk("sat_bits", s_bit_errs, 7);
        chk("sat_words", s_word_errs, 4);
        chk("sat_max", s_max_word_errs, 3);
        chk("sat_flag", s_saturated, 1);

        // Back-to-back: handshake with start clears and re-enters accumulate.
        start = 1'b1; rpt_ready = 1'b1;
        step();
        start = 1'b0; rpt_ready = 1'b0;
        chk("b2b_rpt_valid", rpt_valid, 0);
        chk("b2b_in_ready", in_ready, 1);
        chk("b2b_bits", bit_errs, 0);
        chk("sat_cleared", s_saturated, 0);
        for (int w = 0; w < 4; w++) begin
            in_valid = 1'b1; sent = 3'b000; received = (w == 2) ? 3'b100 : 3'b000;
            step();
        end
        in_valid = 1'b0;
        chk("b2b_second_bits", bit_errs, 1);
        chk("b2b_second_words", word_errs, 1);
        handshake_idle();

        // Gaps, then backpressure while words keep arriving.
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k < 7; k++) begin
            in_valid = (k == 0 || k == 3 || k == 4 || k == 6);
            sent = 3'($urandom); received = 3'($urandom);
            step();
        end
        chk("gap_report", rpt_valid, 1);
        hold_bits = bit_errs;
        for (int k = 0; k < 10; k++) begin
            in_valid = 1'b1; sent = 3'b000; received = 3'b111;
            step();
            chk("hold_bits", bit_errs, hold_bits);
        end
        in_valid = 1'b0;
        handshake_idle();

        // Reset mid-window, then ignored words, then a fresh window.
        start = 1'b1;
        step();
        start = 1'b0;
        for (int w = 0; w < 2; w++) begin
            in_valid = 1'b1; sent = 3'b000; received = 3'b111;
            step();
        end
        in_valid = 1'b0;
        reset = 1'b0;
        step();
        reset = 1'b1;
        chk("rst_mid_bits", bit_errs, 0);
        chk("rst_mid_busy", busy, 0);
        for (int w = 0; w < 3; w++) begin
            in_valid = 1'b1; sent = 3'b000; received = 3'b111;
            step();
        end
        in_valid = 1'b0;
        chk("no_start_bits", bit_errs, 0);
        run_window(1);
        handshake_idle();

        // Random traffic including occasional resets.
        for (int k = 0; k < 400; k++) begin
            reset     = ($urandom_range(0, 60) != 0);
            start     = ($urandom_range(0, 3) == 0);
            in_valid  = ($urandom_range(0, 2) != 0);
            rpt_ready = ($urandom_range(0, 2) == 0);
            sent      = 3'($urandom);
            received  = ($urandom_range(0, 1) == 0) ? sent : 3'($urandom);
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
